hazard_ctrl: RTL and testbench

// Drives the stall/flush side of the IF/ID pipeline register: produces pc_loadbar, if_id_loadbar,
// if_id_flush and id_ex_flush from ID-stage operands, EX-stage load info, branch resolution and

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the IF/ID hazard controller: FSM state
// encoding, the bundled control-output struct and default widths.
package hazard_ctrl_pkg;

  localparam int DEF_REG_W      = 3;
  localparam int DEF_LOAD_DELAY = 1;
  localparam int DEF_CNT_W      = 16;

  // Bubble down-counter is sized for the largest legal LOAD_DELAY (7).
  localparam int BCNT_W = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_loadbar;
    logic if_id_loadbar;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc high and
// sticks at all-ones. Used for debug event counting.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the IF/ID and ID/EX pipeline registers: load-use
// bubbles, taken-branch squash and data-memory freeze, plus debug counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W      = DEF_REG_W,
  parameter int LOAD_DELAY = DEF_LOAD_DELAY,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_loadbar,
  output logic             if_id_loadbar,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t              state;
  logic [BCNT_W-1:0]   bcnt;
  logic                hazard;
  ctrl_t               ctrl;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = ex_mem_read && (ex_rd != '0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      if (mem_busy) begin
        ctrl.pc_loadbar    = 1'b1;
        ctrl.if_id_loadbar = 1'b1;
      end else if (branch_taken) begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if ((state == ST_BUBBLE) || hazard) begin
        ctrl.pc_loadbar    = 1'b1;
        ctrl.if_id_loadbar = 1'b1;
        ctrl.id_ex_flush   = 1'b1;
      end
    end
  end

  assign pc_loadbar    = ctrl.pc_loadbar;
  assign if_id_loadbar = ctrl.if_id_loadbar;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;

  // A memory freeze holds state and bcnt untouched so the bubble resumes
  // exactly where it stopped once the memory is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      bcnt  <= '0;
    end else if (!mem_busy) begin
      if (branch_taken) begin
        state <= ST_RUN;
        bcnt  <= '0;
      end else if (state == ST_BUBBLE) begin
        bcnt <= bcnt - BCNT_W'(1);
        if (bcnt == BCNT_W'(1)) begin
          state <= ST_RUN;
        end
      end else if (hazard && (LOAD_DELAY > 1)) begin
        state <= ST_BUBBLE;
        bcnt  <= BCNT_W'(LOAD_DELAY - 1);
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.pc_loadbar),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.if_id_flush | ctrl.id_ex_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_DELAY=1/CNT_W=8 and
// LOAD_DELAY=3/CNT_W=16) share stimulus and are checked against a cycle model.
module tb_hazard_ctrl;

  localparam int CW_A = 8;
  localparam int CW_B = 16;
  localparam int MAX_A = (1 << CW_A) - 1;
  localparam int MAX_B = (1 << CW_B) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;

  logic            pl_a, il_a, ifl_a, ief_a;
  logic [CW_A-1:0] sc_a, fc_a;
  logic            pl_b, il_b, ifl_b, ief_b;
  logic [CW_B-1:0] sc_b, fc_b;

  int errors = 0;
  int checks = 0;

  // Model state: bubbles still owed after this cycle, and event counts.
  int rem_a, rem_b, st_a, fl_a, st_b, fl_b;

  hazard_ctrl #(.REG_W(3), .LOAD_DELAY(1), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_loadbar(pl_a), .if_id_loadbar(il_a), .if_id_flush(ifl_a),
    .id_ex_flush(ief_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  hazard_ctrl #(.REG_W(3), .LOAD_DELAY(3), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_loadbar(pl_b), .if_id_loadbar(il_b), .if_id_flush(ifl_b),
    .id_ex_flush(ief_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  always #5 clk = ~clk;

  function automatic logic model_hazard();
    return ex_mem_read && (ex_rd != 3'd0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  // Expected {pc_loadbar, if_id_loadbar, if_id_flush, id_ex_flush}.
  function automatic logic [3:0] model_ctrl(int rem);
    if (mem_busy)                  return 4'b1100;
    if (branch_taken)              return 4'b0011;
    if (rem > 0 || model_hazard()) return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic int model_rem(int rem, int ld);
    if (mem_busy)       return rem;
    if (branch_taken)   return 0;
    if (rem > 0)        return rem - 1;
    if (model_hazard()) return ld - 1;
    return 0;
  endfunction

  function automatic int sat_add(int v, logic inc, int max);
    return (inc && v < max) ? v + 1 : v;
  endfunction

  // Applies one cycle of inputs, compares mid-cycle, then advances the model.
  task automatic drive_cycle(input logic mr, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] rt, input logic urt, input logic br,
                             input logic busy);
    logic [3:0] exp_a, exp_b;
    ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; branch_taken = br; mem_busy = busy;
    @(negedge clk);
    exp_a = model_ctrl(rem_a);
    exp_b = model_ctrl(rem_b);
    checks++;
    if ({pl_a, il_a, ifl_a, ief_a} !== exp_a) begin
      errors++;
      $display("FAIL ctrl_a t=%0t got=%b exp=%b", $time, {pl_a, il_a, ifl_a, ief_a}, exp_a);
    end
    checks++;
    if ({pl_b, il_b, ifl_b, ief_b} !== exp_b) begin
      errors++;
      $display("FAIL ctrl_b t=%0t got=%b exp=%b", $time, {pl_b, il_b, ifl_b, ief_b}, exp_b);
    end
    checks++;
    if (sc_a !== st_a[CW_A-1:0] || fc_a !== fl_a[CW_A-1:0]) begin
      errors++;
      $display("FAIL cnt_a t=%0t got=%0d/%0d exp=%0d/%0d", $time, sc_a, fc_a, st_a, fl_a);
    end
    checks++;
    if (sc_b !== st_b[CW_B-1:0] || fc_b !== fl_b[CW_B-1:0]) begin
      errors++;
      $display("FAIL cnt_b t=%0t got=%0d/%0d exp=%0d/%0d", $time, sc_b, fc_b, st_b, fl_b);
    end
    st_a = sat_add(st_a, exp_a[3], MAX_A);
    fl_a = sat_add(fl_a, exp_a[1] | exp_a[0], MAX_A);
    st_b = sat_add(st_b, exp_b[3], MAX_B);
    fl_b = sat_add(fl_b, exp_b[1] | exp_b[0], MAX_B);
    rem_a = model_rem(rem_a, 1);
    rem_b = model_rem(rem_b, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazard_cycle();
    drive_cycle(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rem_a = 0; rem_b = 0; st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rt = 3'd0;
    id_uses_rt = 1'b0; branch_taken = 1'b1; mem_busy = 1'b1;
    @(negedge clk);
    checks++;
    if ({pl_a, il_a, ifl_a, ief_a, pl_b, il_b, ifl_b, ief_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {pl_a, il_a, ifl_a, ief_a, pl_b, il_b, ifl_b, ief_b});
    end
    @(posedge clk);
    #1;
    checks++;
    if (sc_a !== '0 || fc_a !== '0 || sc_b !== '0 || fc_b !== '0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d/%0d/%0d exp=0", sc_a, fc_a, sc_b, fc_b);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    hazard_cycle();
    idle(1);
    checks++;
    if (sc_a !== 8'd1 || fc_a !== 8'd1) begin
      errors++;
      $display("FAIL load_use_cnt got=%0d/%0d exp=1/1", sc_a, fc_a);
    end
    idle(2);
  endtask

  task automatic test_gating();
    do_reset();
    drive_cycle(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sc_a !== 8'd1) begin
      errors++;
      $display("FAIL gating_cnt got=%0d exp=1", sc_a);
    end
    idle(3);
  endtask

  task automatic test_delay3();
    do_reset();
    hazard_cycle();
    idle(4);
    checks++;
    if (sc_b !== 16'd3 || fc_b !== 16'd3 || sc_a !== 8'd1) begin
      errors++;
      $display("FAIL delay3_cnt got=%0d/%0d/%0d exp=3/3/1", sc_b, fc_b, sc_a);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive_cycle(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    hazard_cycle();
    idle(1);
    drive_cycle(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (sc_b !== 16'd2 || fc_b !== 16'd4) begin
      errors++;
      $display("FAIL branch_cnt got=%0d/%0d exp=2/4", sc_b, fc_b);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    hazard_cycle();
    idle(1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    checks++;
    if (sc_b !== 16'd7 || fc_b !== 16'd3) begin
      errors++;
      $display("FAIL freeze_cnt got=%0d/%0d exp=7/3", sc_b, fc_b);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    hazard_cycle();
    ex_mem_read = 1'b0; ex_rd = 3'd0; id_rs = 3'd0;
    #1;
    checks++;
    if (pl_b !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_bubble got=%b exp=1", pl_b);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pl_b, il_b, ifl_b, ief_b} !== 4'b0000 || sc_b !== '0 || fc_b !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b cnt=%0d/%0d exp=0", {pl_b, il_b, ifl_b, ief_b}, sc_b, fc_b);
    end
    reset = 1'b0;
    rem_a = 0; rem_b = 0; st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
    @(negedge clk);
    checks++;
    if (pl_b !== 1'b0) begin
      errors++;
      $display("FAIL async_no_pending got=%b exp=0", pl_b);
    end
    @(posedge clk);
    #1;
    idle(3);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom % 3) == 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 1'($urandom), ($urandom % 8) == 0,
                  ($urandom % 6) == 0);
    end
    checks++;
    if (sc_b !== st_b[CW_B-1:0] || fc_b !== fl_b[CW_B-1:0]) begin
      errors++;
      $display("FAIL random_end_cnt got=%0d/%0d exp=%0d/%0d", sc_b, fc_b, st_b, fl_b);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < (1 << CW_A) + 5; i++) hazard_cycle();
    checks++;
    if (sc_a !== '1 || fc_a !== '1) begin
      errors++;
      $display("FAIL saturation got=%0d/%0d exp=%0d", sc_a, fc_a, MAX_A);
    end
    idle(3);
  endtask

  initial begin
    reset = 1'b1;
    ex_mem_read = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    rem_a = 0; rem_b = 0; st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
    #1;
    test_reset();
    test_load_use();
    test_gating();
    test_delay3();
    test_branch();
    test_freeze();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
